sdsu_master_ctrl: RTL and testbench
===================================

SDSU_MASTER_CTRL -- requirements
Module: sdsu_master_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, meaning operand-queue entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255, meaning maximum cycles spent in WAIT before abort; range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 op_valid  input  1  upstream offers an operand pair.
REQ-006 op_a  input  16  operand A.
REQ-007 op_b  input  16  operand B.
REQ-008 op_ready  output  1  operand queue not full.
REQ-009 bus_valid  output  1  drives the slave valid_signal.
REQ-010 bus_start  output  1  drives the slave start_calc.
REQ-011 bus_a  output  16  operand A to the slave.
REQ-012 bus_b  output  16  operand B to the slave.
REQ-013 bus_rdata  input  32  slave read_data.
REQ-014 bus_ready  input  1  slave ready_signal.
REQ-015 res_valid  output  1  result available downstream.
REQ-016 res_data  output  32  captured result.
REQ-017 res_ready  input  1  downstream accepts the result.
REQ-018 busy  output  1  FSM not in IDLE, or queue not empty.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 The operand queue SHALL push {op_a,op_b} when op_valid && op_ready; op_ready = (count < DEPTH).
REQ-021 The queue SHALL pop exactly once per transaction, on the IDLE->SETUP transition.
REQ-022 A simultaneous push and pop SHALL keep count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have states IDLE, SETUP, START, WAIT, HOLD.
REQ-024 IDLE->SETUP when the queue is non-empty and res_valid is 0; the popped pair SHALL be registered onto bus_a/bus_b.
REQ-025 SETUP (one cycle): bus_valid=1, bus_start=0; next state is START.
REQ-026 START (one cycle): bus_valid=1, bus_start=1; next state is WAIT.
REQ-027 WAIT: bus_valid=0, bus_start=1; bus_a and bus_b held stable.
REQ-028 In WAIT, when bus_ready=1, res_data SHALL capture bus_rdata, res_valid SHALL be set, and the next state is HOLD.
REQ-029 bus_ready SHALL be ignored in every state other than WAIT.
REQ-030 HOLD: bus_start=0; next state is IDLE on the cycle after res_valid && res_ready.
REQ-031 A res_valid && res_ready handshake SHALL clear res_valid; res_data SHALL remain stable while res_valid=1.
REQ-032 Issue latency: a pair pushed into an empty queue while in IDLE SHALL see bus_valid=1 two cycles after the push edge.
REQ-033 Minimum transaction length SHALL be 5 cycles (SETUP, START, WAIT, HOLD, IDLE) with bus_ready arriving on the first WAIT cycle and res_ready held at 1.

Reset
REQ-034 While rst_n=0 at posedge clk, the block SHALL force: state=IDLE, queue empty, op_ready=1, bus_valid=0, bus_start=0, bus_a=0, bus_b=0, res_valid=0, res_data=0, busy=0, err=0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction; queued and captured data SHALL be discarded.
REQ-036 No output SHALL change before the first clock edge with rst_n=0.

Configuration
REQ-037 Macro SDSU_TIMEOUT_EN SHALL control the WAIT timeout.
REQ-038 With SDSU_TIMEOUT_EN defined: a cycle counter SHALL clear on entry to WAIT; reaching TIMEOUT cycles without bus_ready SHALL set err=1, capture res_data=32'hFFFF_FFFF, set res_valid=1 and go to HOLD.
REQ-039 err SHALL stay 1 until reset.
REQ-040 Without SDSU_TIMEOUT_EN: WAIT SHALL persist until bus_ready, err SHALL be tied to 0, and no counter SHALL be instantiated.

Verification
REQ-041 Scenario 1: push A=24, B=30; bench slave model returns A*B after 3 cycles -> SETUP/START/WAIT sequence per REQ-025..027, res_data=720, res_valid=1.
REQ-042 Scenario 2: push 5 pairs back-to-back with DEPTH=4 and the FSM held in WAIT -> op_ready=0 after the 4th push, the 5th pair is not accepted, and later results return in FIFO order.
REQ-043 Scenario 3: res_ready=0 for 10 cycles after a result -> res_data stable, no new SETUP, queue still accepts pushes until full.
REQ-044 Scenario 4: with SDSU_TIMEOUT_EN and TIMEOUT=8, bus_ready never asserted -> err=1 and res_data=32'hFFFF_FFFF at the 8th WAIT cycle.
REQ-045 Scenario 5: rst_n=0 for one cycle while in WAIT with 2 pairs queued -> all outputs at their REQ-034 values next cycle, and a late bus_ready is ignored.
REQ-046 Scenario 6: push and pop on the same cycle with count=DEPTH-1 -> count stays DEPTH-1 and op_ready stays 1.

Source files
------------

// File: rtl/sdsu_master_ctrl.sv
// Bus master for the SDSU multiplier slave: queues operand pairs and sequences SETUP/START/WAIT/HOLD.
// Define SDSU_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles (sets sticky err, returns 32'hFFFF_FFFF).
module sdsu_master_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        op_ready,
    output logic        bus_valid,
    output logic        bus_start,
    output logic [15:0] bus_a,
    output logic [15:0] bus_b,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("sdsu_master_ctrl: DEPTH or TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        push;
    logic        pop;
    logic        res_hs;
    logic        capture;
    logic        timeout_hit;
    logic [31:0] capture_data;

    assign op_ready = (count < CNT_W'(DEPTH));
    assign push     = op_valid && op_ready;
    assign res_hs   = res_valid && res_ready;
    assign busy     = (state != IDLE) || (count != '0);

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        capture      = 1'b0;
        capture_data = bus_rdata;
        bus_valid    = 1'b0;
        bus_start    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !res_valid) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                bus_valid = 1'b1;
                state_nxt = START;
            end
            START: begin
                bus_valid = 1'b1;
                bus_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                bus_start = 1'b1;
                if (bus_ready) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (timeout_hit) begin
                    capture      = 1'b1;
                    capture_data = '1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (res_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {op_a, op_b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_a     <= '0;
            bus_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state <= state_nxt;
            if (pop) {bus_a, bus_b} <= mem[rd_ptr];
            if (capture) begin
                res_data  <= capture_data;
                res_valid <= 1'b1;
            end else if (res_hs) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SDSU_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_q;

    assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));
    assign err         = err_q;

    // Counter idles at zero outside WAIT, so it is already clear on WAIT entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != WAIT)
                wait_cnt <= '0;
            else if (!bus_ready && !timeout_hit)
                wait_cnt <= wait_cnt + 16'd1;
            if (state == WAIT && !bus_ready && timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sdsu_master_ctrl.sv
// Testbench for sdsu_master_ctrl with a small multiplier slave model.
module tb_sdsu_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_ready;
    logic        bus_valid;
    logic        bus_start;
    logic [15:0] bus_a;
    logic [15:0] bus_b;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        err;

    logic        slave_en;
    int unsigned slave_lat;
    int unsigned wait_seen;
    logic        slave_ready;
    logic [31:0] slave_rdata;
    logic        tb_ready;
    logic [31:0] tb_rdata;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] got_q [$];

    localparam logic [2:0] MIN_TBL [10] = '{3'b100, 3'b110, 3'b010, 3'b001, 3'b000,
                                            3'b100, 3'b110, 3'b010, 3'b001, 3'b000};
    localparam logic [15:0] B2B_OP  [5] = '{16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
    localparam logic [31:0] B2B_RES [5] = '{32'd6, 32'd20, 32'd42, 32'd72, 32'd110};
    localparam logic [31:0] HS_RES  [4] = '{32'd2, 32'd12, 32'd30, 32'd56};
    localparam logic [31:0] PP_RES  [5] = '{32'd4, 32'd9, 32'd16, 32'd25, 32'd36};

    assign bus_ready = slave_ready | tb_ready;
    assign bus_rdata = tb_ready ? tb_rdata : slave_rdata;

    always #5 clk = ~clk;

    sdsu_master_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .bus_valid (bus_valid),
        .bus_start (bus_start),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .err       (err)
    );

    // Slave: answers A*B on the slave_lat-th WAIT cycle.
    always @(negedge clk) begin
        if (slave_en && bus_start === 1'b1 && bus_valid === 1'b0) begin
            if (wait_seen == slave_lat - 1) begin
                slave_ready = 1'b1;
                slave_rdata = 32'(bus_a) * 32'(bus_b);
            end else begin
                slave_ready = 1'b0;
            end
            wait_seen++;
        end else begin
            slave_ready = 1'b0;
            wait_seen   = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] a, input logic [15:0] b);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_result();
        for (int unsigned n = 0; n < 20 && res_valid !== 1'b1; n++) tick();
    endtask

    task automatic drain(input int unsigned max_cycles);
        got_q.delete();
        for (int unsigned c = 0; c < max_cycles; c++) begin
            tick();
            if (res_valid === 1'b1) got_q.push_back(res_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({op_ready, bus_valid, bus_start, res_valid, busy, err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {op_ready, bus_valid, bus_start, res_valid, busy, err});
        end
        checks++;
        if (bus_a !== 16'd0 || bus_b !== 16'd0) begin
            failures++;
            $display("FAIL reset_bus: got a=%0h b=%0h expected 0 0", bus_a, bus_b);
        end
        checks++;
        if (res_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_res: got %0h expected 0", res_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int unsigned n;
        res_ready = 1'b0;
        slave_en  = 1'b1;
        slave_lat = 3;
        push_one(16'd24, 16'd30);
        checks++;
        if (bus_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_queued: got valid=%b busy=%b expected 0 1", bus_valid, busy);
        end
        tick();
        checks++;
        if ({bus_valid, bus_start} !== 2'b10 || bus_a !== 16'd24 || bus_b !== 16'd30) begin
            failures++;
            $display("FAIL single_setup: got vs=%b a=%0d b=%0d expected 10 24 30",
                     {bus_valid, bus_start}, bus_a, bus_b);
        end
        tick();
        checks++;
        if ({bus_valid, bus_start} !== 2'b11) begin
            failures++;
            $display("FAIL single_start: got %b expected 11", {bus_valid, bus_start});
        end
        tick();
        checks++;
        if ({bus_valid, bus_start} !== 2'b01 || bus_a !== 16'd24) begin
            failures++;
            $display("FAIL single_wait: got vs=%b a=%0d expected 01 24", {bus_valid, bus_start}, bus_a);
        end
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL single_latency: got %0d wait cycles expected 3", n);
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd720 || bus_start !== 1'b0) begin
            failures++;
            $display("FAIL single_result: got rv=%b data=%0d start=%b expected 1 720 0",
                     res_valid, res_data, bus_start);
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release: got rv=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_min_txn();
        res_ready = 1'b1;
        slave_en  = 1'b1;
        slave_lat = 1;
        op_valid  = 1'b1;
        op_a      = 16'd3;
        op_b      = 16'd7;
        tick();
        op_a = 16'd100;
        op_b = 16'd200;
        for (int k = 0; k < 10; k++) begin
            tick();
            op_valid = 1'b0;
            checks++;
            if ({bus_valid, bus_start, res_valid} !== MIN_TBL[k]) begin
                failures++;
                $display("FAIL min_txn_seq[%0d]: got %b expected %b", k,
                         {bus_valid, bus_start, res_valid}, MIN_TBL[k]);
            end
            if (k == 3) begin
                checks++;
                if (res_data !== 32'd21) begin
                    failures++;
                    $display("FAIL min_txn_res0: got %0d expected 21", res_data);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus_a !== 16'd100) begin
                    failures++;
                    $display("FAIL min_txn_bus_a: got %0d expected 100", bus_a);
                end
            end
            if (k == 8) begin
                checks++;
                if (res_data !== 32'd20000) begin
                    failures++;
                    $display("FAIL min_txn_res1: got %0d expected 20000", res_data);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL min_txn_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        slave_en  = 1'b0;
        slave_lat = 2;
        push_one(16'd2, 16'd3);
        tick();
        tick();
        tick();
        checks++;
        if ({bus_valid, bus_start} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_in_wait: got %b expected 01", {bus_valid, bus_start});
        end
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'b1;
            op_a     = B2B_OP[i];
            op_b     = B2B_OP[i] + 16'd1;
            tick();
            if (i == 2) begin
                checks++;
                if (op_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_3: got %b expected 1", op_ready);
                end
            end
            if (i >= 3) begin
                checks++;
                if (op_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_full[%0d]: got %b expected 0", i, op_ready);
                end
            end
        end
        op_valid = 1'b0;
        slave_en = 1'b1;
        drain(100);
        checks++;
        if (got_q.size() !== 5) begin
            failures++;
            $display("FAIL b2b_count: got %0d results expected 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== B2B_RES[i]) begin
                failures++;
                $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, got_q[i], B2B_RES[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_hold_stall();
        res_ready = 1'b0;
        slave_en  = 1'b1;
        slave_lat = 1;
        push_one(16'd9, 16'd9);
        wait_result();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd81) begin
            failures++;
            $display("FAIL stall_result: got rv=%b data=%0d expected 1 81", res_valid, res_data);
        end
        for (int i = 0; i < 10; i++) begin
            op_valid = (i < 5);
            op_a     = 16'(2 * i + 1);
            op_b     = 16'(2 * i + 2);
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'd81 || bus_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got rv=%b data=%0d bv=%b expected 1 81 0",
                         i, res_valid, res_data, bus_valid);
            end
            if (i == 3) begin
                checks++;
                if (op_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_full: got %b expected 0", op_ready);
                end
            end
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        drain(100);
        checks++;
        if (got_q.size() !== 4) begin
            failures++;
            $display("FAIL stall_count: got %0d results expected 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== HS_RES[i]) begin
                failures++;
                $display("FAIL stall_order[%0d]: got %0d expected %0d", i, got_q[i], HS_RES[i]);
            end
        end
    endtask

    task automatic test_push_pop_same();
        res_ready = 1'b0;
        slave_en  = 1'b1;
        slave_lat = 1;
        push_one(16'd1, 16'd1);
        wait_result();
        for (int i = 2; i <= 4; i++) begin
            op_valid = 1'b1;
            op_a     = 16'(i);
            op_b     = 16'(i);
            tick();
        end
        op_valid = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL pp_three: got ready=%b rv=%b expected 1 1", op_ready, res_valid);
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0 || bus_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pp_idle: got rv=%b bv=%b busy=%b expected 0 0 1", res_valid, bus_valid, busy);
        end
        op_valid = 1'b1;
        op_a     = 16'd5;
        op_b     = 16'd5;
        tick();
        checks++;
        if (op_ready !== 1'b1 || bus_valid !== 1'b1 || bus_a !== 16'd2) begin
            failures++;
            $display("FAIL pp_same_cycle: got ready=%b bv=%b a=%0d expected 1 1 2",
                     op_ready, bus_valid, bus_a);
        end
        op_a = 16'd6;
        op_b = 16'd6;
        tick();
        op_valid = 1'b0;
        checks++;
        if (op_ready !== 1'b0) begin
            failures++;
            $display("FAIL pp_fill: got %b expected 0", op_ready);
        end
        drain(150);
        checks++;
        if (got_q.size() !== 5) begin
            failures++;
            $display("FAIL pp_count: got %0d results expected 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== PP_RES[i]) begin
                failures++;
                $display("FAIL pp_order[%0d]: got %0d expected %0d", i, got_q[i], PP_RES[i]);
            end
        end
    endtask

`ifdef SDSU_TIMEOUT_EN
    task automatic test_timeout();
        res_ready = 1'b0;
        slave_en  = 1'b0;
        push_one(16'd7, 16'd7);
        tick();
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (err !== 1'b0 || res_valid !== 1'b0 || bus_start !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got err=%b rv=%b start=%b expected 0 0 1", err, res_valid, bus_start);
        end
        tick();
        checks++;
        if (err !== 1'b1 || res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL timeout_hit: got err=%b rv=%b data=%0h expected 1 1 ffffffff",
                     err, res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: got err=%b busy=%b expected 1 0", err, busy);
        end
    endtask
`endif

    task automatic test_reset_mid();
        res_ready = 1'b1;
        slave_en  = 1'b0;
        push_one(16'd11, 16'd12);
        tick();
        tick();
        tick();
        push_one(16'd13, 16'd14);
        push_one(16'd15, 16'd16);
        checks++;
        if ({bus_valid, bus_start} !== 2'b01 || bus_a !== 16'd11) begin
            failures++;
            $display("FAIL rmid_wait: got vs=%b a=%0d expected 01 11", {bus_valid, bus_start}, bus_a);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({op_ready, bus_valid, bus_start, res_valid, busy, err} !== 6'b100000) begin
            failures++;
            $display("FAIL rmid_ctrl: got %b expected 100000",
                     {op_ready, bus_valid, bus_start, res_valid, busy, err});
        end
        checks++;
        if (bus_a !== 16'd0 || bus_b !== 16'd0 || res_data !== 32'd0) begin
            failures++;
            $display("FAIL rmid_data: got a=%0h b=%0h data=%0h expected 0 0 0", bus_a, bus_b, res_data);
        end
        tb_rdata = 32'hDEAD_BEEF;
        tb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0 || res_data !== 32'd0 || busy !== 1'b0 || bus_valid !== 1'b0) begin
                failures++;
                $display("FAIL rmid_late_ready[%0d]: got rv=%b data=%0h busy=%b bv=%b expected 0 0 0 0",
                         i, res_valid, res_data, busy, bus_valid);
            end
        end
        tb_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        op_valid    = 1'b0;
        op_a        = '0;
        op_b        = '0;
        res_ready   = 1'b0;
        tb_ready    = 1'b0;
        tb_rdata    = '0;
        slave_en    = 1'b0;
        slave_lat   = 1;
        wait_seen   = 0;
        slave_ready = 1'b0;
        slave_rdata = '0;

        test_reset();
        test_single();
        test_min_txn();
        test_back_to_back();
        test_hold_stall();
        test_push_pop_same();
`ifdef SDSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
